// File: rtl/x_skew_feeder.sv
// Buffers input vectors in a small FIFO and launches them into a systolic array,
// at most one vector every GAP cycles, with element r skewed by r cycles onto row r.
module x_skew_feeder #(
  parameter int N     = 4,
  parameter int GAP   = 4,
  parameter int DEPTH = 4
) (
  input  logic                     I_CLK,
  input  logic                     I_RST_N,
  input  logic                     I_VEC_VLD,
  input  logic [16*N-1:0]          I_VEC,
  output logic                     O_VEC_RDY,
  output logic [N-1:0]             O_X_VLD,
  output logic [16*N-1:0]          O_X,
  output logic [$clog2(DEPTH):0]   O_FIFO_CNT,
  output logic                     O_BUSY
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  state_e          state_q, state_d;
  logic [7:0]      gap_q, gap_d;
  logic [PW-1:0]   wr_q, rd_q;
  logic [CW-1:0]   cnt_q;
  logic [16*N-1:0] mem_q [DEPTH];
  logic [16*N-1:0] head;
  logic            push, pop, launch_ok;
  logic [N-1:0]    row_busy;

  // Ready depends on the registered count only, never on I_VEC_VLD.
  assign O_VEC_RDY  = (cnt_q < CW'(DEPTH));
  assign push       = I_VEC_VLD && O_VEC_RDY;
  assign head       = mem_q[rd_q];
  assign O_FIFO_CNT = cnt_q;

  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    pop       = 1'b0;
    launch_ok = (state_q == S_IDLE) || (gap_q == 8'd0);
    if (launch_ok) begin
      if (cnt_q != '0) begin
        pop     = 1'b1;
        gap_d   = 8'(GAP - 1);
        state_d = (GAP > 1) ? S_WAIT : S_IDLE;
      end else begin
        state_d = S_IDLE;
      end
    end else begin
      gap_d = gap_q - 8'd1;
    end
  end

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state_q <= S_IDLE;
      gap_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge I_CLK) begin
    if (push) mem_q[wr_q] <= I_VEC;
  end

  // Row r has r+1 register stages; data stages only load on a valid so the
  // final stage holds the last launched element between pulses.
  for (genvar r = 0; r < N; r++) begin : g_row
    logic signed [15:0] x_q [r+1];
    logic [r:0]         v_q;

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
      if (!I_RST_N) begin
        v_q <= '0;
        for (int s = 0; s <= r; s++) x_q[s] <= '0;
      end else begin
        v_q[0] <= pop;
        if (pop) x_q[0] <= head[16*r +: 16];
        for (int s = 1; s <= r; s++) begin
          v_q[s] <= v_q[s-1];
          if (v_q[s-1]) x_q[s] <= x_q[s-1];
        end
      end
    end

    assign O_X[16*r +: 16] = x_q[r];
    assign O_X_VLD[r]      = v_q[r];
    assign row_busy[r]     = |v_q;
  end

  assign O_BUSY = (cnt_q != '0) || (state_q == S_WAIT) || (|row_busy);

endmodule

// File: tb/tb_x_skew_feeder.sv
// Bench for x_skew_feeder: a queue-and-launch-time reference model predicts
// every output after each clock edge; a second instance covers GAP=1.
module tb_x_skew_feeder;
  localparam int N = 4, GAP = 4, DEPTH = 4;
  localparam int CW = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          vld, rdy, busy;
  logic [63:0]   vec, x;
  logic [3:0]    xv;
  logic [CW-1:0] cnt;
  logic          vld1, rdy1, busy1;
  logic [63:0]   vec1, x1;
  logic [3:0]    xv1;
  logic [CW-1:0] cnt1;

  x_skew_feeder #(.N(N), .GAP(GAP), .DEPTH(DEPTH)) dut (
    .I_CLK(clk), .I_RST_N(rst_n), .I_VEC_VLD(vld), .I_VEC(vec),
    .O_VEC_RDY(rdy), .O_X_VLD(xv), .O_X(x), .O_FIFO_CNT(cnt), .O_BUSY(busy));

  x_skew_feeder #(.N(N), .GAP(1), .DEPTH(DEPTH)) dut1 (
    .I_CLK(clk), .I_RST_N(rst_n), .I_VEC_VLD(vld1), .I_VEC(vec1),
    .O_VEC_RDY(rdy1), .O_X_VLD(xv1), .O_X(x1), .O_FIFO_CNT(cnt1), .O_BUSY(busy1));

  // Reference model state
  logic [63:0]   q [$];
  logic [63:0]   launch_at [int];
  logic [15:0]   hold [N];
  int            last_l, cyc;
  bit            acc;
  logic [3:0]    exp_vld;
  logic [63:0]   exp_x;
  logic [CW-1:0] exp_cnt;
  logic          exp_rdy, exp_busy;
  int            checks, errors;

  task automatic clear_model();
    q.delete();
    launch_at.delete();
    last_l = -1000;
    for (int r = 0; r < N; r++) hold[r] = '0;
  endtask

  // Drive one cycle of input, advance the model across the edge, settle 1ns.
  task automatic step(input logic v, input logic [63:0] d);
    bit do_push, do_pop;
    int e;
    logic [63:0] tmp;
    vld = v;
    vec = d;
    do_push = v && (q.size() < DEPTH);
    do_pop  = (q.size() > 0) && (cyc + 1 >= last_l + GAP);
    @(posedge clk);
    cyc++;
    e = cyc;
    if (do_pop) begin
      launch_at[e] = q.pop_front();
      last_l = e;
    end
    if (do_push) q.push_back(d);
    acc = do_push;
    exp_vld = '0;
    for (int r = 0; r < N; r++) begin
      if (launch_at.exists(e - r)) begin
        exp_vld[r] = 1'b1;
        tmp = launch_at[e - r];
        hold[r] = tmp[16*r +: 16];
      end
      exp_x[16*r +: 16] = hold[r];
    end
    exp_cnt  = CW'(q.size());
    exp_rdy  = (q.size() < DEPTH);
    exp_busy = (q.size() > 0) || (GAP > 1 && e < last_l + GAP) || (e <= last_l + N - 1);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({xv, x, cnt, busy} !== '0 || rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_async vld=%b x=%h cnt=%0d busy=%b rdy=%b, required all 0 and rdy=1", xv, x, cnt, busy, rdy);
    end
    repeat (2) begin @(posedge clk); cyc++; end
    #1 rst_n = 1'b1;
    #1;
    checks++;
    if (rdy !== 1'b1 || cnt !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release rdy=%b cnt=%0d busy=%b, required rdy=1 cnt=0 busy=0", rdy, cnt, busy);
    end
  endtask

  task automatic test_single();
    logic [63:0] v;
    int ae, k;
    logic [3:0] ev;
    logic [15:0] ex;
    logic eb;
    v = {16'h2000, 16'h1000, 16'hE000, 16'h0001};
    repeat (3) step(1'b0, '0);
    step(1'b1, v);
    ae = cyc;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, '0);
      checks++;
      if ({xv, x, cnt, rdy, busy} !== {exp_vld, exp_x, exp_cnt, exp_rdy, exp_busy}) begin
        errors++;
        $display("FAIL single cyc=%0d vld=%b/%b x=%h/%h cnt=%0d/%0d rdy=%b/%b busy=%b/%b",
                 cyc, xv, exp_vld, x, exp_x, cnt, exp_cnt, rdy, exp_rdy, busy, exp_busy);
      end
      k = cyc - ae;
      if (k >= 1 && k <= 5) begin
        case (k)
          1: begin ev = 4'b0001; ex = 16'h0001; eb = 1'b1; end
          2: begin ev = 4'b0010; ex = 16'hE000; eb = 1'b1; end
          3: begin ev = 4'b0100; ex = 16'h1000; eb = 1'b1; end
          4: begin ev = 4'b1000; ex = 16'h2000; eb = 1'b1; end
          default: begin ev = 4'b0000; ex = 16'h0000; eb = 1'b0; end
        endcase
        checks++;
        if (xv !== ev || busy !== eb || (k < 5 && x[16*(k-1) +: 16] !== ex)) begin
          errors++;
          $display("FAIL single_skew k=%0d vld=%b busy=%b x=%h, required vld=%b busy=%b elem=%h",
                   k, xv, busy, x, ev, eb, ex);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] vs [6];
    int idx, n3, prev0;
    bit saw_full;
    for (int i = 0; i < 6; i++) vs[i] = {$urandom, $urandom};
    idx = 0; n3 = 0; prev0 = -1; saw_full = 0;
    for (int i = 0; i < 32; i++) begin
      step(idx < 6, (idx < 6) ? vs[idx] : 64'd0);
      if (acc) idx++;
      checks++;
      if ({xv, x, cnt, rdy, busy} !== {exp_vld, exp_x, exp_cnt, exp_rdy, exp_busy}) begin
        errors++;
        $display("FAIL b2b cyc=%0d vld=%b/%b x=%h/%h cnt=%0d/%0d rdy=%b/%b busy=%b/%b",
                 cyc, xv, exp_vld, x, exp_x, cnt, exp_cnt, rdy, exp_rdy, busy, exp_busy);
      end
      if (!rdy) saw_full = 1;
      if (xv[0]) begin
        if (prev0 >= 0) begin
          checks++;
          if (cyc - prev0 !== GAP) begin
            errors++;
            $display("FAIL b2b_spacing got %0d cycles, required %0d", cyc - prev0, GAP);
          end
        end
        prev0 = cyc;
      end
      if (xv[3]) begin
        checks++;
        if (n3 >= 6 || x[63:48] !== vs[n3][63:48]) begin
          errors++;
          $display("FAIL b2b_order row3 #%0d got %h, required %h", n3, x[63:48], vs[n3 % 6][63:48]);
        end
        n3++;
      end
    end
    checks++;
    if (n3 !== 6 || saw_full !== 1'b1 || idx !== 6) begin
      errors++;
      $display("FAIL b2b_totals row3_out=%0d accepted=%0d saw_full=%b, required 6 6 1", n3, idx, saw_full);
    end
  endtask

  task automatic test_simul();
    bit pat [6];
    pat[0] = 1; pat[1] = 1; pat[2] = 1; pat[3] = 1; pat[4] = 0; pat[5] = 1;
    for (int i = 0; i < 24; i++) begin
      step((i < 6) ? pat[i] : 1'b0, {$urandom, $urandom});
      checks++;
      if ({xv, x, cnt, rdy, busy} !== {exp_vld, exp_x, exp_cnt, exp_rdy, exp_busy}) begin
        errors++;
        $display("FAIL simul cyc=%0d vld=%b/%b x=%h/%h cnt=%0d/%0d rdy=%b/%b busy=%b/%b",
                 cyc, xv, exp_vld, x, exp_x, cnt, exp_cnt, rdy, exp_rdy, busy, exp_busy);
      end
      if (i == 5) begin
        checks++;
        if (cnt !== 3'd3 || rdy !== 1'b1) begin
          errors++;
          $display("FAIL simul_pushpop cnt=%0d rdy=%b, required cnt=3 rdy=1", cnt, rdy);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    repeat (3) step(1'b1, {$urandom, $urandom});
    checks++;
    if (cnt !== 3'd2 || busy !== 1'b1 || xv !== 4'b0010) begin
      errors++;
      $display("FAIL rmid_pre cnt=%0d busy=%b vld=%b, required cnt=2 busy=1 vld=0010", cnt, busy, xv);
    end
    #1 rst_n = 1'b0;
    vld = 1'b0;
    clear_model();
    #1;
    checks++;
    if ({xv, x, cnt, busy} !== '0) begin
      errors++;
      $display("FAIL rmid_async vld=%b x=%h cnt=%0d busy=%b, required all 0", xv, x, cnt, busy);
    end
    repeat (2) begin @(posedge clk); cyc++; end
    #1 rst_n = 1'b1;
    #1;
    checks++;
    if (rdy !== 1'b1) begin
      errors++;
      $display("FAIL rmid_rdy got %b, required 1", rdy);
    end
    for (int i = 0; i < 18; i++) begin
      step(i == 10, {$urandom, $urandom});
      checks++;
      if ({xv, x, cnt, rdy, busy} !== {exp_vld, exp_x, exp_cnt, exp_rdy, exp_busy} || (i < 10 && xv !== 4'b0)) begin
        errors++;
        $display("FAIL rmid_after cyc=%0d vld=%b/%b x=%h/%h cnt=%0d/%0d rdy=%b/%b busy=%b/%b",
                 cyc, xv, exp_vld, x, exp_x, cnt, exp_cnt, rdy, exp_rdy, busy, exp_busy);
      end
    end
  endtask

  task automatic test_idle_gap();
    logic [63:0] v;
    v = {$urandom, $urandom};
    repeat (10) step(1'b0, '0);
    step(1'b1, v);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, '0);
      checks++;
      if ({xv, x, cnt, rdy, busy} !== {exp_vld, exp_x, exp_cnt, exp_rdy, exp_busy}) begin
        errors++;
        $display("FAIL idle_gap cyc=%0d vld=%b/%b x=%h/%h cnt=%0d/%0d rdy=%b/%b busy=%b/%b",
                 cyc, xv, exp_vld, x, exp_x, cnt, exp_cnt, rdy, exp_rdy, busy, exp_busy);
      end
      if (i == 0) begin
        checks++;
        if (xv !== 4'b0001 || x[15:0] !== v[15:0]) begin
          errors++;
          $display("FAIL idle_gap_launch vld=%b x0=%h, required vld=0001 x0=%h", xv, x[15:0], v[15:0]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 430; i++) begin
      step((i < 400) && ($urandom_range(0, 2) != 0), {$urandom, $urandom});
      checks++;
      if ({xv, x, cnt, rdy, busy} !== {exp_vld, exp_x, exp_cnt, exp_rdy, exp_busy}) begin
        errors++;
        $display("FAIL random cyc=%0d vld=%b/%b x=%h/%h cnt=%0d/%0d rdy=%b/%b busy=%b/%b",
                 cyc, xv, exp_vld, x, exp_x, cnt, exp_cnt, rdy, exp_rdy, busy, exp_busy);
      end
    end
    checks++;
    if (cnt !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL random_drain cnt=%0d busy=%b, required 0 0", cnt, busy);
    end
  endtask

  task automatic test_gap1();
    logic [63:0] vs1 [3];
    logic [9:0] h0, h3;
    int n;
    for (int i = 0; i < 3; i++) vs1[i] = {$urandom, $urandom};
    h0 = '0; h3 = '0; n = 0;
    for (int i = 0; i < 10; i++) begin
      vld1 = (i < 3);
      vec1 = (i < 3) ? vs1[i] : 64'd0;
      step(1'b0, '0);
      h0[i] = xv1[0];
      h3[i] = xv1[3];
      if (xv1[3]) begin
        checks++;
        if (n >= 3 || x1[63:48] !== vs1[n][63:48]) begin
          errors++;
          $display("FAIL gap1_row3 #%0d got %h, required %h", n, x1[63:48], vs1[n % 3][63:48]);
        end
        n++;
      end
    end
    vld1 = 1'b0;
    checks++;
    if (h0 !== 10'b0000001110 || h3 !== 10'b0001110000 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL gap1_pattern row0=%b row3=%b busy=%b, required 0000001110 0001110000 0",
               h0, h3, busy1);
    end
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; acc = 0;
    vld = 1'b0; vec = '0; vld1 = 1'b0; vec1 = '0;
    clear_model();
    test_reset();
    test_single();
    test_back_to_back();
    test_simul();
    test_reset_mid();
    test_idle_gap();
    test_random();
    test_gap1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout simulation did not complete within time limit");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/x_skew_feeder.md
X_SKEW_FEEDER -- requirements
Module: x_skew_feeder

Interface
REQ-001 The block SHALL expose the parameter N, default 4, giving the number of PE rows fed (1..16).
REQ-002 The block SHALL expose the parameter GAP, default 4, giving the minimum cycles between consecutive vector launches on row 0 (1..255).
REQ-003 The block SHALL expose the parameter DEPTH, default 4, giving the input FIFO depth in vectors (power of 2, 2..16).
REQ-004 Port I_CLK, input, 1 bit: clock; all state changes on its rising edge.
REQ-005 Port I_RST_N, input, 1 bit: reset, asynchronous, active-low.
REQ-006 Port I_VEC_VLD, input, 1 bit: an input vector is offered.
REQ-007 Port I_VEC, input, 16*N bits: the vector; element r is bits [16r+15:16r], Q2.13 signed, not modified by this block.
REQ-008 Port O_VEC_RDY, output, 1 bit: the FIFO can accept a vector this cycle.
REQ-009 Port O_X_VLD, output, N bits: bit r is the one-cycle valid to the I_X_VLD input of the row-r PE.
REQ-010 Port O_X, output, 16*N bits: element r is the X value for the row-r PE.
REQ-011 Port O_FIFO_CNT, output, $clog2(DEPTH)+1 bits: current FIFO occupancy.
REQ-012 Port O_BUSY, output, 1 bit: data is queued or in flight.

Function
REQ-013 Accept: a vector SHALL be written into the FIFO at a rising edge where I_VEC_VLD=1 and O_VEC_RDY=1; otherwise it SHALL be ignored.
REQ-014 Ready: O_VEC_RDY SHALL equal (O_FIFO_CNT < DEPTH), decoded from registered state only, with no combinational path from I_VEC_VLD.
REQ-015 Count on a simultaneous push and pop: O_FIFO_CNT SHALL be unchanged and the data SHALL not be corrupted.
REQ-016 Count on push alone or pop alone: O_FIFO_CNT SHALL change by +1 or -1, and the read/write pointers SHALL wrap modulo DEPTH.
REQ-017 The launch FSM SHALL have exactly two states, IDLE and WAIT.
REQ-018 IDLE transition: if O_FIFO_CNT>0, the FSM SHALL pop the head vector, launch it, load the gap counter with GAP-1, and go to WAIT if GAP>1, else stay in IDLE; if O_FIFO_CNT=0 it SHALL remain in IDLE.
REQ-019 WAIT behaviour: while the gap counter is nonzero it SHALL decrement by 1 per cycle.
REQ-020 WAIT exit: at the edge where the gap counter is 0, the FSM SHALL behave exactly as IDLE does (pop and launch if CNT>0, else go to IDLE), so back-to-back launches are exactly GAP cycles apart.
REQ-021 Skew: for a launch at edge k, element r SHALL appear on O_X[r] with O_X_VLD[r]=1 for the single cycle following edge k+r, through an r-stage register delay line per row.
REQ-022 Latency: with the FIFO empty and the FSM in IDLE, a vector accepted at edge t SHALL be launched at edge t+1, and O_X_VLD[0] SHALL be high in the cycle after t+1.
REQ-023 When O_X_VLD[r]=0, O_X[r] SHALL hold its last launched value.
REQ-024 Each O_X_VLD bit SHALL pulse for exactly one cycle per vector.
REQ-025 O_BUSY SHALL be 1 whenever O_FIFO_CNT>0, the FSM is in WAIT, or any delay-line valid bit is set, and 0 otherwise.
REQ-026 FIFO full: while CNT=DEPTH, O_VEC_RDY SHALL be 0, and on the same edge a pop occurs O_VEC_RDY SHALL return to 1 in the next cycle.
REQ-027 FIFO empty during WAIT: the FSM SHALL return to IDLE when the gap counter expires.
REQ-028 Arrival after an empty WAIT: a vector arriving later SHALL launch under IDLE rules, with no extra gap inserted.

Reset
REQ-029 While I_RST_N=0, the block SHALL force O_X_VLD=0, O_X=0, O_FIFO_CNT=0, O_BUSY=0, FSM=IDLE, gap counter=0, pointers=0, and all delay-line registers=0, immediately and without waiting for a clock edge.
REQ-030 After reset, O_VEC_RDY SHALL read 1.
REQ-031 Reset mid-operation SHALL discard all queued and in-flight vectors, with no residual valid pulses after release.

Verification
REQ-032 Single vector: N=4, GAP=4, vector {0x2000,0x1000,0xE000,0x0001} accepted at edge 5 -> O_X_VLD = 0001,0010,0100,1000 in the cycles after edges 6,7,8,9, with O_X[r] holding the matching element; O_BUSY falls after edge 10.
REQ-033 Back-to-back: I_VEC_VLD held for 6 vectors (V0..V5) with DEPTH=4 -> row-0 launches exactly every 4 cycles; O_VEC_RDY drops when CNT=4; all 6 vectors emerge in order with none lost or duplicated.
REQ-034 GAP=1: 3 consecutive vectors -> O_X_VLD[0] high for 3 consecutive cycles, and row 3 shows the same pattern 3 cycles later.
REQ-035 Simultaneous push/pop at CNT=DEPTH-1: CNT stays 3 and O_VEC_RDY stays 1.
REQ-036 Reset mid-operation: I_RST_N pulsed low while CNT=2 and rows 1..3 are in flight -> all outputs go to 0 asynchronously, O_VEC_RDY=1 after release, and no O_X_VLD pulse appears until a new vector is accepted.
REQ-037 Idle gap: after the FIFO drains, a vector arriving 10 cycles later -> launched one edge after acceptance, with no extra gap.
